lane_collision_scorer: RTL and testbench
========================================

# lane_collision_scorer

Per-frame collision and scoring engine for the multi-lane car game. Each lane's falling object is classified against its car as hit, miss or collect. The block fires one event per object, however long the object stays in the car band. It keeps the score, lives and game state, and feeds the display and sound blocks downstream of the game logic.

## Interface
- NUM_LANES, 2, number of car/object lanes
- XW, 10, x coordinate width
- YW, 9, y coordinate width
- CAR_W, 17, car width in pixels
- CAR_H, 34, car height in pixels
- OBJ_HALF, 6, object half-width in pixels
- SCORE_W, 8, score width (saturating)
- LIVES, 3, lives per game
- COOLDOWN_FRAMES, 30, frames of invulnerability after a loss
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame; the only evaluation instant
- start  in  1  level, sampled each cycle; begins a new game
- car_x  in  NUM_LANES*XW  car left edge per lane, lane 0 in LSBs
- car_y  in  YW  shared car top edge
- obj_valid  in  NUM_LANES  object present in lane
- obj_hazard  in  NUM_LANES  1 = hazard (square), 0 = collectible
- obj_x  in  NUM_LANES*XW  object centre x per lane
- obj_y  in  NUM_LANES*YW  object y per lane
- collect_pulse  out  NUM_LANES  one-cycle pulse per lane on collect
- loss_pulse  out  1  one-cycle pulse when a life is lost
- score  out  SCORE_W  current score
- lives  out  $clog2(LIVES+1)  remaining lives
- state  out  2  IDLE=0, PLAY=1, COOLDOWN=2, OVER=3
- game_over  out  1  high while state==OVER

## Operation
- Per lane, in_band = obj_valid && obj_y >= car_y && obj_y <= car_y+CAR_H.
- Per lane, aligned = obj_x >= car_x+OBJ_HALF && obj_x+OBJ_HALF <= car_x+CAR_W.
- Band and alignment arithmetic is done at XW+1 / YW+1 bits. No subtraction is used, so nothing wraps.
- Lane class when in_band: hazard && aligned = HIT; !hazard && aligned = COLLECT; !hazard && !aligned = MISS; hazard && !aligned = NONE (dodged).
- Per-lane consumed flag, set when a HIT, MISS or COLLECT is evaluated. While it is set, the lane produces no further events. It clears on a tick where in_band==0.
- FSM states and transitions:
  - IDLE -> PLAY on start.
  - PLAY -> COOLDOWN on any loss, or -> OVER if that loss takes lives to 0.
  - COOLDOWN -> PLAY after COOLDOWN_FRAMES ticks.
  - OVER -> PLAY on start.
- start in PLAY or COOLDOWN is ignored.
- Entering PLAY from start sets score=0, lives=LIVES and clears all consumed flags.
- Loss handling:
  - Any number of HIT/MISS lanes on one tick costs exactly one life.
  - In COOLDOWN, losses are ignored, but the lanes are still marked consumed.
- Collect handling:
  - Collects score in PLAY and COOLDOWN: +1 per collecting lane on the same tick.
  - Score saturates at 2^SCORE_W-1.
- Loss and collect on different lanes in the same tick both apply.
- In IDLE and OVER, ticks are ignored entirely and flags are untouched.

## Timing
- Reset values: state=IDLE, score=0, lives=LIVES, all pulses 0, game_over=0, consumed=0, cooldown counter=0.
- Inputs are sampled on the frame_tick cycle. Pulses, score, lives and state update on the next edge (latency 1 cycle), and pulses are high for exactly one cycle.
- Cooldown counter loads COOLDOWN_FRAMES-1 on entry and decrements per tick. The tick that sees 0 returns to PLAY, giving exactly COOLDOWN_FRAMES ticks of invulnerability.
- start and frame_tick in the same cycle in IDLE/OVER: start wins and the tick is not evaluated.
- rst mid-game: immediate return to the reset values, with no pulse emitted.

## Structure
- Shared game_pkg holds:
  - the state enum;
  - the lane class enum (NONE/HIT/MISS/COLLECT);
  - the default geometry constants CAR_W, CAR_H, OBJ_HALF.
- Sub-module lane_classifier: combinational, one lane, produces the class from car_x, car_y, obj_*. Generated NUM_LANES times.
- Top level holds the consumed flags, FSM, counters and popcount of collects.

## Test plan
- car_y=400, car_x[0]=100, hazard obj_x=108, obj_y=410, tick -> loss_pulse 1 cycle later, lives 3->2, state COOLDOWN.
- Collectible at obj_x=108, obj_y=410 held for 6 ticks -> exactly one collect_pulse[0], score 0->1, score stays 1.
- Collectible at obj_x=130 in band -> MISS, lives decrement. Hazard at obj_x=130 -> no event.
- Both lanes HIT on one tick -> lives drop by 1 only. Second hazard 10 ticks later -> ignored; state back to PLAY exactly 30 ticks after entry.
- Three losses spaced >30 ticks -> lives 0, state OVER, game_over=1. Later ticks have no effect; start -> PLAY, score 0, lives 3.
- Wrap and saturation checks:
  - car_x=0, collectible obj_x=3 in band -> MISS, not COLLECT (no wrap).
  - With SCORE_W=2, 5 collects -> score 3.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and default geometry for the lane collision
//                scorer: game state encoding, per-lane classification
//                result, and car/object dimensions in pixels.
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    // Encoding is visible on the state output port, so values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAY     = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_OVER     = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        CLS_NONE    = 2'd0,
        CLS_HIT     = 2'd1,
        CLS_MISS    = 2'd2,
        CLS_COLLECT = 2'd3
    } lane_class_t;

    localparam int CAR_W    = 17;
    localparam int CAR_H    = 34;
    localparam int OBJ_HALF = 6;

endpackage
`default_nettype wire

// File: rtl/lane_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : lane_classifier
//  Description : Combinational classification of one lane's object against
//                its car. Comparisons are widened by one bit and only use
//                addition, so coordinates near 0 or the top of the range
//                never wrap into a false match.
//  Ports       : car_x, car_y         car left/top edge
//                obj_valid, obj_hazard object present / hazard type
//                obj_x, obj_y         object centre x / y
//                in_band              object overlaps the car rows
//                cls                  NONE / HIT / MISS / COLLECT
//  Revision    : 1.0  initial release
// ============================================================================
module lane_classifier #(
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int CAR_W    = game_pkg::CAR_W,
    parameter int CAR_H    = game_pkg::CAR_H,
    parameter int OBJ_HALF = game_pkg::OBJ_HALF
) (
    input  logic [XW-1:0]          car_x,
    input  logic [YW-1:0]          car_y,
    input  logic                   obj_valid,
    input  logic                   obj_hazard,
    input  logic [XW-1:0]          obj_x,
    input  logic [YW-1:0]          obj_y,
    output logic                   in_band,
    output game_pkg::lane_class_t  cls
);
    import game_pkg::*;

    localparam logic [XW:0] c_car_w    = (XW+1)'(CAR_W);
    localparam logic [XW:0] c_obj_half = (XW+1)'(OBJ_HALF);
    localparam logic [YW:0] c_car_h    = (YW+1)'(CAR_H);

    logic [XW:0] w_car_x;
    logic [XW:0] w_obj_x;
    logic [YW:0] w_car_y;
    logic [YW:0] w_obj_y;
    logic        w_aligned;

    assign w_car_x = {1'b0, car_x};
    assign w_obj_x = {1'b0, obj_x};
    assign w_car_y = {1'b0, car_y};
    assign w_obj_y = {1'b0, obj_y};

    assign in_band   = obj_valid && (w_obj_y >= w_car_y) && (w_obj_y <= w_car_y + c_car_h);
    assign w_aligned = (w_obj_x >= w_car_x + c_obj_half) && (w_obj_x + c_obj_half <= w_car_x + c_car_w);

    always_comb begin
        cls = CLS_NONE;
        if (in_band) begin
            unique case ({obj_hazard, w_aligned})
                2'b11:   cls = CLS_HIT;
                2'b01:   cls = CLS_COLLECT;
                2'b00:   cls = CLS_MISS;
                default: cls = CLS_NONE;   // hazard dodged
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_collision_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : lane_collision_scorer
//  Description : Per-frame collision/scoring engine. Each lane fires at most
//                one event per object (consumed flag), losses cost one life
//                per tick, collects add to a saturating score, and a
//                cooldown window makes the player invulnerable after a loss.
//  Ports       : clk, rst (async, active-high), frame_tick, start
//                car_x, car_y, obj_valid, obj_hazard, obj_x, obj_y  (lanes)
//                collect_pulse, loss_pulse  one-cycle event pulses
//                score, lives, state, game_over
//  Revision    : 1.0  initial release
// ============================================================================
module lane_collision_scorer #(
    parameter int NUM_LANES       = 2,
    parameter int XW              = 10,
    parameter int YW              = 9,
    parameter int CAR_W           = game_pkg::CAR_W,
    parameter int CAR_H           = game_pkg::CAR_H,
    parameter int OBJ_HALF        = game_pkg::OBJ_HALF,
    parameter int SCORE_W         = 8,
    parameter int LIVES           = 3,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_tick,
    input  logic                        start,
    input  logic [NUM_LANES*XW-1:0]     car_x,
    input  logic [YW-1:0]               car_y,
    input  logic [NUM_LANES-1:0]        obj_valid,
    input  logic [NUM_LANES-1:0]        obj_hazard,
    input  logic [NUM_LANES*XW-1:0]     obj_x,
    input  logic [NUM_LANES*YW-1:0]     obj_y,
    output logic [NUM_LANES-1:0]        collect_pulse,
    output logic                        loss_pulse,
    output logic [SCORE_W-1:0]          score,
    output logic [$clog2(LIVES+1)-1:0]  lives,
    output logic [1:0]                  state,
    output logic                        game_over
);
    import game_pkg::*;

    localparam int c_lives_w = $clog2(LIVES+1);
    localparam int c_cd_w    = $clog2(COOLDOWN_FRAMES+1);
    localparam int c_cnt_w   = $clog2(NUM_LANES+1);
    localparam int c_sum_w   = SCORE_W + c_cnt_w;
    localparam logic [SCORE_W-1:0] c_score_max = '1;

    game_state_t            r_state;
    game_state_t            w_state_nxt;
    logic [NUM_LANES-1:0]   r_consumed;
    logic [c_cd_w-1:0]      r_cd_cnt;

    lane_class_t            w_cls [NUM_LANES];
    logic [NUM_LANES-1:0]   w_in_band;
    logic [NUM_LANES-1:0]   w_consumed_nxt;
    logic [NUM_LANES-1:0]   w_collect;
    logic                   w_hit_any;
    logic [c_cnt_w-1:0]     w_cnt;
    logic [c_sum_w-1:0]     w_sum;
    logic [SCORE_W-1:0]     w_score_nxt;
    logic                   w_active;
    logic                   w_loss;
    logic                   w_start;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_classifier #(
            .XW       (XW),
            .YW       (YW),
            .CAR_W    (CAR_W),
            .CAR_H    (CAR_H),
            .OBJ_HALF (OBJ_HALF)
        ) u_classifier (
            .car_x      (car_x[g*XW +: XW]),
            .car_y      (car_y),
            .obj_valid  (obj_valid[g]),
            .obj_hazard (obj_hazard[g]),
            .obj_x      (obj_x[g*XW +: XW]),
            .obj_y      (obj_y[g*YW +: YW]),
            .in_band    (w_in_band[g]),
            .cls        (w_cls[g])
        );
    end

    // Per-lane event filtering: a lane that already produced an event stays
    // silent until its object leaves the band. A dodged hazard neither sets
    // nor clears the flag.
    always_comb begin
        w_consumed_nxt = r_consumed;
        w_collect      = '0;
        w_hit_any      = 1'b0;
        w_cnt          = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!w_in_band[i]) begin
                w_consumed_nxt[i] = 1'b0;
            end else if (w_cls[i] != CLS_NONE) begin
                w_consumed_nxt[i] = 1'b1;
                if (!r_consumed[i]) begin
                    if (w_cls[i] == CLS_COLLECT) w_collect[i] = 1'b1;
                    else                         w_hit_any    = 1'b1;
                end
            end
            w_cnt = w_cnt + c_cnt_w'(w_collect[i]);
        end
    end

    always_comb begin
        w_sum       = c_sum_w'(score) + c_sum_w'(w_cnt);
        w_score_nxt = (w_sum > c_sum_w'(c_score_max)) ? c_score_max : w_sum[SCORE_W-1:0];
    end

    assign w_active = frame_tick && (r_state == ST_PLAY || r_state == ST_COOLDOWN);
    assign w_loss   = frame_tick && (r_state == ST_PLAY) && w_hit_any;
    assign w_start  = start && (r_state == ST_IDLE || r_state == ST_OVER);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM: next state. start takes priority over a coincident tick.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:     if (start) w_state_nxt = ST_PLAY;
            ST_PLAY:     if (frame_tick && w_hit_any)
                             w_state_nxt = (lives == c_lives_w'(1)) ? ST_OVER : ST_COOLDOWN;
            ST_COOLDOWN: if (frame_tick && r_cd_cnt == '0) w_state_nxt = ST_PLAY;
            ST_OVER:     if (start) w_state_nxt = ST_PLAY;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        state     = r_state;
        game_over = (r_state == ST_OVER);
    end

    // Score, lives, cooldown counter, consumed flags and event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_consumed    <= '0;
            r_cd_cnt      <= '0;
            score         <= '0;
            lives         <= c_lives_w'(LIVES);
            collect_pulse <= '0;
            loss_pulse    <= 1'b0;
        end else begin
            collect_pulse <= w_active ? w_collect : '0;
            loss_pulse    <= w_loss;
            if (w_start) begin
                r_consumed <= '0;
                score      <= '0;
                lives      <= c_lives_w'(LIVES);
            end else if (w_active) begin
                r_consumed <= w_consumed_nxt;
                score      <= w_score_nxt;
                if (w_loss) begin
                    lives    <= lives - c_lives_w'(1);
                    r_cd_cnt <= c_cd_w'(COOLDOWN_FRAMES - 1);
                end else if (r_state == ST_COOLDOWN && r_cd_cnt != '0) begin
                    r_cd_cnt <= r_cd_cnt - c_cd_w'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_collision_scorer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lane_collision_scorer
//  Description : Self-checking bench for lane_collision_scorer. Two DUT
//                copies share all inputs: the default one and one with a
//                2-bit score to exercise saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lane_collision_scorer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        start;
    logic [19:0] car_x;
    logic [8:0]  car_y;
    logic [1:0]  obj_valid;
    logic [1:0]  obj_hazard;
    logic [19:0] obj_x;
    logic [17:0] obj_y;

    logic [1:0]  collect_pulse, collect_pulse2;
    logic        loss_pulse, loss_pulse2;
    logic [7:0]  score;
    logic [1:0]  score2;
    logic [1:0]  lives, lives2;
    logic [1:0]  state, state2;
    logic        game_over, game_over2;

    always #5 clk = ~clk;

    lane_collision_scorer u_dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .car_x(car_x), .car_y(car_y), .obj_valid(obj_valid), .obj_hazard(obj_hazard),
        .obj_x(obj_x), .obj_y(obj_y), .collect_pulse(collect_pulse), .loss_pulse(loss_pulse),
        .score(score), .lives(lives), .state(state), .game_over(game_over)
    );

    lane_collision_scorer #(.SCORE_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .car_x(car_x), .car_y(car_y), .obj_valid(obj_valid), .obj_hazard(obj_hazard),
        .obj_x(obj_x), .obj_y(obj_y), .collect_pulse(collect_pulse2), .loss_pulse(loss_pulse2),
        .score(score2), .lives(lives2), .state(state2), .game_over(game_over2)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int       m_state, m_score, m_score2, m_lives, m_cd_left;
    bit [1:0] m_cons, m_cp;
    bit       m_lp;

    function automatic void model_reset();
        m_state = 0; m_score = 0; m_score2 = 0; m_lives = 3; m_cd_left = 0;
        m_cons = 2'b00; m_cp = 2'b00; m_lp = 1'b0;
    endfunction

    // -1 = not in band, 0 none, 1 hit, 2 miss, 3 collect
    function automatic int lane_event(int l);
        int cx, cy, ox, oy;
        bit aligned;
        cx = int'(car_x[l*10 +: 10]);
        cy = int'(car_y);
        ox = int'(obj_x[l*10 +: 10]);
        oy = int'(obj_y[l*9 +: 9]);
        if (!(obj_valid[l] && oy >= cy && oy <= cy + 34)) return -1;
        aligned = (ox >= cx + 6) && (ox + 6 <= cx + 17);
        if (obj_hazard[l]) return aligned ? 1 : 0;
        return aligned ? 3 : 2;
    endfunction

    function automatic void model_step(bit tk, bit st);
        int  ncoll;
        bit  lost;
        int  ev;
        m_cp = 2'b00; m_lp = 1'b0;
        if ((m_state == 0 || m_state == 3) && st) begin
            m_state = 1; m_score = 0; m_score2 = 0; m_lives = 3; m_cons = 2'b00;
            return;
        end
        if (!tk || m_state == 0 || m_state == 3) return;
        ncoll = 0; lost = 1'b0;
        for (int l = 0; l < 2; l++) begin
            ev = lane_event(l);
            if (ev < 0) m_cons[l] = 1'b0;
            else if (ev > 0) begin
                if (!m_cons[l]) begin
                    if (ev == 3) begin ncoll++; m_cp[l] = 1'b1; end
                    else lost = 1'b1;
                end
                m_cons[l] = 1'b1;
            end
        end
        if (m_state == 1 && lost) begin
            m_lp = 1'b1;
            m_lives--;
            if (m_lives == 0) m_state = 3;
            else begin m_state = 2; m_cd_left = 30; end
        end else if (m_state == 2) begin
            m_cd_left--;
            if (m_cd_left == 0) m_state = 1;
        end
        m_score  = (m_score + ncoll > 255) ? 255 : m_score + ncoll;
        m_score2 = (m_score2 + ncoll > 3) ? 3 : m_score2 + ncoll;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit tk, input bit st);
        frame_tick = tk;
        start      = st;
        model_step(tk, st);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
    endtask

    task automatic tick_gap();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic set_lane(input int l, input bit v, input bit hz, input int cx, input int ox, input int oy);
        car_x[l*10 +: 10]   = 10'(cx);
        obj_valid[l]        = v;
        obj_hazard[l]       = hz;
        obj_x[l*10 +: 10]   = 10'(ox);
        obj_y[l*9 +: 9]     = 9'(oy);
    endtask

    task automatic clear_objs();
        obj_valid = 2'b00;
    endtask

    task automatic fresh_game();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        car_y = 9'd400;
        set_lane(0, 1'b0, 1'b0, 100, 0, 0);
        set_lane(1, 1'b0, 1'b0, 300, 0, 0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_vec++; if (state !== 2'd0)    begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
        n_vec++; if (score !== 8'd0)    begin n_err++; $display("FAIL reset_score got %0d want 0", score); end
        n_vec++; if (lives !== 2'd3)    begin n_err++; $display("FAIL reset_lives got %0d want 3", lives); end
        n_vec++; if (game_over !== 1'b0 || loss_pulse !== 1'b0 || collect_pulse !== 2'b00)
            begin n_err++; $display("FAIL reset_outputs got go=%b lp=%b cp=%b want 0", game_over, loss_pulse, collect_pulse); end
        car_y = 9'd400;
        set_lane(0, 1'b1, 1'b0, 100, 108, 410);
        cyc(1'b1, 1'b0);
        n_vec++; if (state !== 2'd0 || score !== 8'd0 || collect_pulse !== 2'b00)
            begin n_err++; $display("FAIL idle_tick got st=%0d sc=%0d cp=%b want 0/0/00", state, score, collect_pulse); end
    endtask

    task automatic test_hit();
        fresh_game();
        n_vec++; if (state !== 2'd1 || lives !== 2'd3)
            begin n_err++; $display("FAIL start_play got st=%0d lv=%0d want 1/3", state, lives); end
        set_lane(0, 1'b1, 1'b1, 100, 108, 410);
        cyc(1'b1, 1'b0);
        n_vec++; if (loss_pulse !== 1'b1) begin n_err++; $display("FAIL hit_pulse got %b want 1", loss_pulse); end
        n_vec++; if (lives !== 2'd2 || state !== 2'd2)
            begin n_err++; $display("FAIL hit_lives_state got lv=%0d st=%0d want 2/2", lives, state); end
        cyc(1'b0, 1'b0);
        n_vec++; if (loss_pulse !== 1'b0) begin n_err++; $display("FAIL hit_pulse_width got %b want 0", loss_pulse); end
    endtask

    task automatic test_collect_once();
        int pulses;
        fresh_game();
        set_lane(0, 1'b1, 1'b0, 100, 108, 410);
        pulses = 0;
        for (int t = 0; t < 6; t++) begin
            cyc(1'b1, 1'b0);
            if (collect_pulse[0]) pulses++;
            cyc(1'b0, 1'b0);
            if (collect_pulse[0]) pulses++;
        end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL collect_once pulses got %0d want 1", pulses); end
        n_vec++; if (score !== 8'd1) begin n_err++; $display("FAIL collect_score got %0d want 1", score); end
        clear_objs();
        tick_gap();
        n_vec++; if (score !== 8'd1) begin n_err++; $display("FAIL collect_hold got %0d want 1", score); end
    endtask

    task automatic test_miss_dodge();
        fresh_game();
        set_lane(0, 1'b1, 1'b0, 100, 130, 410);
        cyc(1'b1, 1'b0);
        n_vec++; if (loss_pulse !== 1'b1 || lives !== 2'd2 || collect_pulse !== 2'b00)
            begin n_err++; $display("FAIL miss got lp=%b lv=%0d cp=%b want 1/2/00", loss_pulse, lives, collect_pulse); end
        clear_objs();
        repeat (30) tick_gap();
        n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL miss_recover got %0d want 1", state); end
        set_lane(0, 1'b1, 1'b1, 100, 130, 410);
        cyc(1'b1, 1'b0);
        n_vec++; if (loss_pulse !== 1'b0 || lives !== 2'd2 || state !== 2'd1)
            begin n_err++; $display("FAIL dodge got lp=%b lv=%0d st=%0d want 0/2/1", loss_pulse, lives, state); end
    endtask

    task automatic test_double_hit_cooldown();
        fresh_game();
        set_lane(0, 1'b1, 1'b1, 100, 108, 410);
        set_lane(1, 1'b1, 1'b1, 300, 308, 410);
        cyc(1'b1, 1'b0);
        n_vec++; if (lives !== 2'd2 || loss_pulse !== 1'b1)
            begin n_err++; $display("FAIL double_hit got lv=%0d lp=%b want 2/1", lives, loss_pulse); end
        cyc(1'b0, 1'b0);
        clear_objs();
        repeat (9) tick_gap();
        set_lane(0, 1'b1, 1'b1, 100, 108, 410);
        cyc(1'b1, 1'b0);
        n_vec++; if (loss_pulse !== 1'b0 || lives !== 2'd2 || state !== 2'd2)
            begin n_err++; $display("FAIL cooldown_ignore got lp=%b lv=%0d st=%0d want 0/2/2", loss_pulse, lives, state); end
        cyc(1'b0, 1'b0);
        clear_objs();
        repeat (19) tick_gap();
        n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL cooldown_29 got %0d want 2", state); end
        tick_gap();
        n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL cooldown_30 got %0d want 1", state); end
    endtask

    task automatic test_game_over();
        fresh_game();
        for (int k = 0; k < 3; k++) begin
            set_lane(0, 1'b1, 1'b1, 100, 108, 410);
            cyc(1'b1, 1'b0);
            if (k < 2) begin
                clear_objs();
                repeat (31) tick_gap();
            end
        end
        n_vec++; if (state !== 2'd3 || game_over !== 1'b1 || lives !== 2'd0)
            begin n_err++; $display("FAIL game_over got st=%0d go=%b lv=%0d want 3/1/0", state, game_over, lives); end
        clear_objs();
        tick_gap();
        set_lane(1, 1'b1, 1'b0, 300, 308, 410);
        tick_gap();
        n_vec++; if (state !== 2'd3 || score !== 8'd0 || collect_pulse !== 2'b00)
            begin n_err++; $display("FAIL over_ignores got st=%0d sc=%0d want 3/0", state, score); end
        set_lane(0, 1'b1, 1'b1, 100, 108, 410);
        cyc(1'b1, 1'b1);
        n_vec++; if (state !== 2'd1 || lives !== 2'd3 || score !== 8'd0 || loss_pulse !== 1'b0 || game_over !== 1'b0)
            begin n_err++; $display("FAIL restart got st=%0d lv=%0d sc=%0d lp=%b want 1/3/0/0", state, lives, score, loss_pulse); end
    endtask

    task automatic test_wrap();
        fresh_game();
        set_lane(0, 1'b1, 1'b0, 0, 3, 410);
        cyc(1'b1, 1'b0);
        n_vec++; if (collect_pulse !== 2'b00 || loss_pulse !== 1'b1 || lives !== 2'd2)
            begin n_err++; $display("FAIL wrap got cp=%b lp=%b lv=%0d want 00/1/2", collect_pulse, loss_pulse, lives); end
    endtask

    task automatic test_saturation();
        fresh_game();
        for (int k = 0; k < 5; k++) begin
            set_lane(0, 1'b1, 1'b0, 100, 108, 410);
            tick_gap();
            clear_objs();
            tick_gap();
        end
        n_vec++; if (score2 !== 2'd3) begin n_err++; $display("FAIL sat_score got %0d want 3", score2); end
        n_vec++; if (score !== 8'd5)  begin n_err++; $display("FAIL wide_score got %0d want 5", score); end
    endtask

    task automatic test_reset_mid();
        fresh_game();
        set_lane(0, 1'b1, 1'b0, 100, 108, 410);
        set_lane(1, 1'b1, 1'b1, 300, 308, 410);
        frame_tick = 1'b1;
        @(posedge clk);
        #2;
        frame_tick = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if (state !== 2'd0 || score !== 8'd0 || lives !== 2'd3 || loss_pulse !== 1'b0 || collect_pulse !== 2'b00)
            begin n_err++; $display("FAIL mid_reset got st=%0d sc=%0d lv=%0d lp=%b cp=%b want 0/0/3/0/00",
                                    state, score, lives, loss_pulse, collect_pulse); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_objs();
    endtask

    task automatic test_random();
        int cy, cx, ox, oy;
        bit tk, st;
        fresh_game();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) car_y = 9'($urandom_range(300, 420));
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 7) == 0) car_x[l*10 +: 10] = 10'($urandom_range(0, 1000));
                    cx = int'(car_x[l*10 +: 10]);
                    cy = int'(car_y);
                    ox = cx + int'($urandom_range(0, 32)) - 8;
                    oy = cy + int'($urandom_range(0, 60)) - 10;
                    if (ox < 0) ox = 0;
                    if (ox > 1023) ox = 1023;
                    if (oy < 0) oy = 0;
                    if (oy > 511) oy = 511;
                    set_lane(l, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), cx, ox, oy);
                end
            end
            tk = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 49) == 0);
            cyc(tk, st);
            n_vec++;
            if (state !== 2'(m_state) || score !== 8'(m_score) || lives !== 2'(m_lives) ||
                collect_pulse !== m_cp || loss_pulse !== m_lp || game_over !== (m_state == 3) ||
                score2 !== 2'(m_score2) || state2 !== state || lives2 !== lives ||
                loss_pulse2 !== loss_pulse || collect_pulse2 !== collect_pulse || game_over2 !== game_over) begin
                n_err++;
                $display("FAIL random cyc=%0d got st=%0d sc=%0d sc2=%0d lv=%0d cp=%b lp=%b go=%b want st=%0d sc=%0d sc2=%0d lv=%0d cp=%b lp=%b",
                         c, state, score, score2, lives, collect_pulse, loss_pulse, game_over,
                         m_state, m_score, m_score2, m_lives, m_cp, m_lp);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        start      = 1'b0;
        car_x      = '0;
        car_y      = '0;
        obj_valid  = '0;
        obj_hazard = '0;
        obj_x      = '0;
        obj_y      = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_hit();
        test_collect_once();
        test_miss_dodge();
        test_double_hit_cooldown();
        test_game_over();
        test_wrap();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
